mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001: The module SHALL have a single clock and a synchronous, active-low reset, with ports listed below in this order.
REQ-002: clk  input  1  system clock; all state changes on its rising edge.
REQ-003: reset  input  1  synchronous, active-low reset.
REQ-004: fetch_req  input  1  code-fetch request from the CU; held until fetch_ack.
REQ-005: fetch_addr  input  16  code address; held stable with fetch_req.
REQ-006: x_req  input  1  MOVX request; held until x_ack.
REQ-007: x_wr  input  1  1 = XDATA write, 0 = XDATA read; held with x_req.
REQ-008: x_addr  input  16  XDATA address; held with x_req.
REQ-009: x_wdata  input  8  write data; held with x_req.
REQ-010: P0_in  input  8  external data bus sampled on reads.
REQ-011: P0_out  output  8  multiplexed address-low/write-data drive.
REQ-012: P0_oe  output  1  P0 output enable.
REQ-013: P2_out  output  8  address-high drive.
REQ-014: ALE  output  1  address latch enable, active-high.
REQ-015: PSEN  output  1  program store enable, active-low.
REQ-016: RD  output  1  XDATA read strobe, active-low.
REQ-017: WR  output  1  XDATA write strobe, active-low.
REQ-018: rdata  output  8  data captured by the last read or fetch.
REQ-019: fetch_ack  output  1  one-clock pulse; fetch complete, rdata valid.
REQ-020: x_ack  output  1  one-clock pulse; MOVX complete (rdata valid for reads).
REQ-021: busy  output  1  high while state is not IDLE.

Function
REQ-022: The FSM SHALL have two states, IDLE and ACCESS, and a 4-bit counter cnt that runs 0..11 in ACCESS.
REQ-023: In IDLE with any request high, the FSM SHALL grant one requester, latch its address, data and type, and enter ACCESS with cnt=0 on the next edge.
REQ-024: When only one request is high, that requester SHALL be granted.
REQ-025: When both requests are high, arbitration SHALL be round-robin via a last_x flag: last_x=1 grants fetch, last_x=0 grants x. last_x updates on every grant and resets to 0.
REQ-026: For cnt 0..3, P0_out SHALL be the latched addr[7:0] with P0_oe=1; P2_out SHALL be the latched addr[15:8] for cnt 0..11.
REQ-027: ALE SHALL be 1 for cnt 0..2 and 0 otherwise.
REQ-028: For cnt 4..10, exactly one strobe SHALL be low: PSEN for a fetch, RD for an XDATA read, WR for an XDATA write.
REQ-029: For cnt 4..11 on a write, P0_out SHALL be the latched wdata with P0_oe=1; on a read or fetch, P0_oe SHALL be 0.
REQ-030: On a read or fetch, rdata SHALL capture P0_in at the edge that ends cnt=10; rdata SHALL be unchanged on writes.
REQ-031: During cnt=11, the matching ack SHALL be 1 for exactly one clock; the FSM SHALL then return to IDLE unconditionally.
REQ-032: Grant-to-ack latency SHALL be 12 clocks, and back-to-back accesses SHALL be separated by one IDLE clock (13-clock period).
REQ-033: Requests and request-field changes arriving during ACCESS SHALL be ignored until IDLE, and the latched fields SHALL be used throughout the access.
REQ-034: The requester SHALL drop its request in the clock after its ack. A request still high in IDLE SHALL be treated as a new request.

Reset
REQ-035: When reset=0 at an edge, the following SHALL be forced: state=IDLE, cnt=0, ALE=0, PSEN=RD=WR=1, P0_oe=0, P0_out=8'hFF, P2_out=8'hFF, rdata=8'h00, fetch_ack=x_ack=0, busy=0, last_x=0.
REQ-036: A reset during ACCESS SHALL abort the access with no ack, and the strobe SHALL be high from the following clock.
REQ-037: Idle output values SHALL equal the reset values, except rdata, which SHALL hold its value.

Verification
REQ-038: The bench SHALL cover a fetch: fetch_req=1, fetch_addr=16'h1234, P0_in=8'hA5 -> ALE high 3 clocks, P0_out=8'h34, P2_out=8'h12, PSEN low 7 clocks, fetch_ack 12 clocks after grant, rdata=8'hA5.
REQ-039: The bench SHALL cover an XDATA write: x_req=1, x_wr=1, x_addr=16'h00FF, x_wdata=8'h5A -> WR low at cnt 4..10, P0_out=8'h5A with P0_oe=1 at cnt 4..11, PSEN and RD stay high, x_ack pulses once.
REQ-040: The bench SHALL cover contention: fetch_req and x_req both held high from reset -> grant order x, fetch, x, with a 13-clock spacing between acks.
REQ-041: The bench SHALL cover reset at cnt=6 of an XDATA read -> RD=1 on the next clock, no x_ack, busy=0, rdata=8'h00.
REQ-042: The bench SHALL cover a request-field change mid-access: x_addr changed at cnt=5 -> P2_out keeps the latched high byte until cnt=11.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// External memory bus controller: arbitrates code fetches and MOVX accesses onto a
// multiplexed P0/P2 bus with ALE, PSEN, RD and WR strobes (12-clock access cycle).
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [15:0] fetch_addr,
  input  logic        x_req,
  input  logic        x_wr,
  input  logic [15:0] x_addr,
  input  logic [7:0]  x_wdata,
  input  logic [7:0]  P0_in,
  output logic [7:0]  P0_out,
  output logic        P0_oe,
  output logic [7:0]  P2_out,
  output logic        ALE,
  output logic        PSEN,
  output logic        RD,
  output logic        WR,
  output logic [7:0]  rdata,
  output logic        fetch_ack,
  output logic        x_ack,
  output logic        busy
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StAccess = 1'b1;

  localparam logic [3:0] CntLast    = 4'd11;
  localparam logic [3:0] CntCapture = 4'd10;

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_last_x;
  logic        r_is_x;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic [7:0]  r_rdata;

  logic w_any_req;
  logic w_grant_x;
  logic w_strobe_phase;

  assign w_any_req = fetch_req | x_req;
  // Round-robin on contention: the requester that was not served last wins.
  assign w_grant_x = x_req & (~fetch_req | ~r_last_x);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_last_x <= 1'b0;
      r_is_x   <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 16'h0000;
      r_wdata  <= 8'h00;
      r_rdata  <= 8'h00;
    end else if (r_state == StIdle) begin
      if (w_any_req) begin
        r_state  <= StAccess;
        r_cnt    <= 4'd0;
        r_last_x <= w_grant_x;
        r_is_x   <= w_grant_x;
        r_wr     <= w_grant_x & x_wr;
        r_addr   <= w_grant_x ? x_addr : fetch_addr;
        r_wdata  <= x_wdata;
      end
    end else begin
      if (r_cnt == CntLast) begin
        r_state <= StIdle;
        r_cnt   <= 4'd0;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
      if ((r_cnt == CntCapture) && !r_wr) begin
        r_rdata <= P0_in;
      end
    end
  end

  assign w_strobe_phase = (r_cnt >= 4'd4) && (r_cnt <= 4'd10);

  always_comb begin
    P0_out    = 8'hFF;
    P0_oe     = 1'b0;
    P2_out    = 8'hFF;
    ALE       = 1'b0;
    PSEN      = 1'b1;
    RD        = 1'b1;
    WR        = 1'b1;
    fetch_ack = 1'b0;
    x_ack     = 1'b0;
    busy      = 1'b0;
    if (r_state == StAccess) begin
      busy   = 1'b1;
      P2_out = r_addr[15:8];
      ALE    = (r_cnt < 4'd3);
      if (r_cnt < 4'd4) begin
        P0_out = r_addr[7:0];
        P0_oe  = 1'b1;
      end else if (r_wr) begin
        P0_out = r_wdata;
        P0_oe  = 1'b1;
      end
      if (w_strobe_phase) begin
        if (!r_is_x) begin
          PSEN = 1'b0;
        end else if (r_wr) begin
          WR = 1'b0;
        end else begin
          RD = 1'b0;
        end
      end
      if (r_cnt == CntLast) begin
        fetch_ack = ~r_is_x;
        x_ack     = r_is_x;
      end
    end
  end

  assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: per-cycle bus checks with a scoreboard of
// expected ack type and read data.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_req = 1'b0;
  logic [15:0] fetch_addr = 16'h0000;
  logic        x_req = 1'b0;
  logic        x_wr = 1'b0;
  logic [15:0] x_addr = 16'h0000;
  logic [7:0]  x_wdata = 8'h00;
  logic [7:0]  P0_in = 8'h00;
  logic [7:0]  P0_out;
  logic        P0_oe;
  logic [7:0]  P2_out;
  logic        ALE;
  logic        PSEN;
  logic        RD;
  logic        WR;
  logic [7:0]  rdata;
  logic        fetch_ack;
  logic        x_ack;
  logic        busy;

  typedef struct {
    logic       is_x;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .x_req      (x_req),
    .x_wr       (x_wr),
    .x_addr     (x_addr),
    .x_wdata    (x_wdata),
    .P0_in      (P0_in),
    .P0_out     (P0_out),
    .P0_oe      (P0_oe),
    .P2_out     (P2_out),
    .ALE        (ALE),
    .PSEN       (PSEN),
    .RD         (RD),
    .WR         (WR),
    .rdata      (rdata),
    .fetch_ack  (fetch_ack),
    .x_ack      (x_ack),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ctrl"}, {8'h00, ALE, PSEN, RD, WR, P0_oe, fetch_ack, x_ack, busy},
        {8'h00, 8'b0111_0000});
    chk({tag, " bus"}, {P0_out, P2_out}, 16'hFFFF);
  endtask

  // Walks one access from the grant edge through the ack cycle, checking every bus cycle.
  task automatic run_access(input string name, input logic is_x, input logic wr,
                            input logic [15:0] addr, input logic [7:0] wdata,
                            input bit perturb, output int ack_cyc);
    int   ale_n;
    int   strb_n;
    logic s;
    exp_t e;
    ale_n   = 0;
    strb_n  = 0;
    ack_cyc = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (perturb && c == 5) begin
        x_addr  = 16'hABCD;
        x_wr    = ~x_wr;
        x_wdata = 8'h00;
      end
      s = (c >= 4) && (c <= 10);
      if (ALE) ale_n++;
      if (!PSEN || !RD || !WR) strb_n++;
      chk($sformatf("%s c%0d busy", name, c), busy, 1);
      chk($sformatf("%s c%0d p2", name, c), P2_out, addr[15:8]);
      chk($sformatf("%s c%0d ale", name, c), ALE, (c < 3));
      if (c < 4) begin
        chk($sformatf("%s c%0d p0addr", name, c), {P0_oe, P0_out}, {1'b1, addr[7:0]});
      end else if (wr) begin
        chk($sformatf("%s c%0d p0wdata", name, c), {P0_oe, P0_out}, {1'b1, wdata});
      end else begin
        chk($sformatf("%s c%0d p0oe", name, c), P0_oe, 0);
      end
      chk($sformatf("%s c%0d strobes", name, c), {PSEN, RD, WR},
          {~(s & ~is_x), ~(s & is_x & ~wr), ~(s & is_x & wr)});
      chk($sformatf("%s c%0d acks", name, c), {fetch_ack, x_ack},
          {(c == 11) & ~is_x, (c == 11) & is_x});
      if (fetch_ack || x_ack) begin
        ack_cyc = cyc;
        if (sb_q.size() == 0) begin
          chk({name, " sb_empty"}, 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk({name, " ack_type"}, x_ack, e.is_x);
          chk({name, " rdata"}, rdata, e.data);
        end
      end
    end
    chk({name, " ale_cycles"}, ale_n[15:0], 3);
    chk({name, " strobe_cycles"}, strb_n[15:0], 7);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int t0;
    int t1;
    int t2;
    int t3;

    // Reset values
    tick();
    tick();
    chk_idle("reset");
    chk("reset rdata", rdata, 8'h00);
    reset = 1'b1;
    tick();
    chk_idle("idle0");

    // Code fetch
    fetch_addr = 16'h1234;
    P0_in      = 8'hA5;
    fetch_req  = 1'b1;
    sb_q.push_back('{1'b0, 8'hA5});
    run_access("fetch", 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, t0);
    fetch_req = 1'b0;
    tick();
    chk_idle("post_fetch");
    chk("post_fetch rdata", rdata, 8'hA5);

    // XDATA write leaves rdata alone
    P0_in   = 8'h3C;
    x_addr  = 16'h00FF;
    x_wdata = 8'h5A;
    x_wr    = 1'b1;
    x_req   = 1'b1;
    sb_q.push_back('{1'b1, 8'hA5});
    run_access("xwr", 1'b1, 1'b1, 16'h00FF, 8'h5A, 1'b0, t0);
    x_req = 1'b0;
    tick();
    chk_idle("post_xwr");
    chk("post_xwr rdata", rdata, 8'hA5);

    // XDATA read with request fields changed at cnt=5
    P0_in  = 8'h77;
    x_addr = 16'h4321;
    x_wr   = 1'b0;
    x_req  = 1'b1;
    sb_q.push_back('{1'b1, 8'h77});
    run_access("xchg", 1'b1, 1'b0, 16'h4321, 8'h00, 1'b1, t0);
    x_req = 1'b0;
    x_wr  = 1'b0;
    tick();
    chk_idle("post_xchg");
    chk("post_xchg rdata", rdata, 8'h77);

    // Contention from reset: x, fetch, x
    reset      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 16'h1234;
    x_req      = 1'b1;
    x_wr       = 1'b0;
    x_addr     = 16'h5555;
    P0_in      = 8'h99;
    tick();
    tick();
    chk_idle("cont_reset");
    reset = 1'b1;
    sb_q.push_back('{1'b1, 8'h99});
    sb_q.push_back('{1'b0, 8'h99});
    sb_q.push_back('{1'b1, 8'h99});
    run_access("cont1_x", 1'b1, 1'b0, 16'h5555, 8'h00, 1'b0, t1);
    tick();
    chk_idle("cont_gap1");
    run_access("cont2_f", 1'b0, 1'b0, 16'h1234, 8'h00, 1'b0, t2);
    tick();
    chk_idle("cont_gap2");
    run_access("cont3_x", 1'b1, 1'b0, 16'h5555, 8'h00, 1'b0, t3);
    chk("cont spacing12", (t2 - t1), 13);
    chk("cont spacing23", (t3 - t2), 13);
    fetch_req = 1'b0;
    x_req     = 1'b0;
    tick();
    chk_idle("post_cont");

    // Reset at cnt=6 of an XDATA read aborts it
    P0_in  = 8'hEE;
    x_addr = 16'h2468;
    x_wr   = 1'b0;
    x_req  = 1'b1;
    for (int c = 0; c < 7; c++) tick();
    chk("abort rd_low_c6", {busy, RD}, 2'b10);
    reset = 1'b0;
    x_req = 1'b0;
    tick();
    chk("abort rd", RD, 1);
    chk("abort busy", busy, 0);
    chk("abort rdata", rdata, 8'h00);
    chk_idle("abort");
    reset = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      chk($sformatf("abort noack%0d", c), {fetch_ack, x_ack, busy}, 3'b000);
    end

    chk("sb drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
